quant_threshold_bank: RTL and testbench

- Parametrised successor to the fixed H/S/V colour-reduction threshold registers.
- Holds one keep-bit count and derived MSB mask per colour channel, for any channel count and pixel width.
- Edits arrive as load/increment/decrement/restore commands. They land in a shadow set, which is copied to the active set only on a frame boundary, so a frame is never quantised with mixed thresholds.
- Sits between the switch/button control logic and the per-pixel quantiser in the colour-reduction path.

---
 rtl/quant_threshold_bank.sv | 183 ++++++++++++++++++
 tb/tb_quant_threshold_bank.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/quant_threshold_bank.sv
// quant_threshold_bank
//   Per-channel keep-bit thresholds for the colour-reduction quantiser.
//   Edits from the control logic land in a shadow set. The shadow set is
//   copied to the active set only on a frame boundary. This keeps every
//   frame quantised with a single, consistent set of thresholds.
//
// Optional build macro: QTHRESH_ROUND_EN
//   When this macro is defined, the module adds the round_out port. That port
//   carries a half-LSB rounding offset for each channel.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous reset, active low
//   cmd_valid    in   single-cycle command strobe
//   cmd_op       in   00 LOAD, 01 INC, 10 DEC, 11 RESTORE
//   cmd_ch       in   target channel
//   cmd_val      in   keep count for LOAD
//   frame_start  in   one-cycle pulse at the start of a frame
//   mask_out     out  active MSB masks, channel 0 in the LSBs
//   keep_out     out  active keep counts, channel 0 in the LSBs
//   pending      out  shadow edits are waiting for frame_start
//   update_done  out  one-cycle pulse after the active set was reloaded
//   cmd_err      out  one-cycle pulse after a rejected or clamped command
//   round_out    out  (QTHRESH_ROUND_EN only) rounding offsets, channel 0 in the LSBs
module quant_threshold_bank #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 8,
  parameter logic [NUM_CH*4-1:0] DEF_KEEP = {4'd2, 4'd2, 4'd3},
  localparam int KW = $clog2(DATA_W + 1),
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_op,
  input  logic [CW-1:0]            cmd_ch,
  input  logic [KW-1:0]            cmd_val,
  input  logic                     frame_start,
  output logic [NUM_CH*DATA_W-1:0] mask_out,
  output logic [NUM_CH*KW-1:0]     keep_out,
  output logic                     pending,
`ifdef QTHRESH_ROUND_EN
  output logic [NUM_CH*DATA_W-1:0] round_out,
`endif
  output logic                     update_done,
  output logic                     cmd_err
);

  localparam logic [1:0]    OP_LOAD = 2'b00;
  localparam logic [1:0]    OP_INC  = 2'b01;
  localparam logic [1:0]    OP_DEC  = 2'b10;
  localparam logic [KW-1:0] K_MAX   = KW'(DATA_W);
  localparam logic [KW-1:0] K_MIN   = KW'(1);
  localparam logic [CW:0]   CH_LIM  = (CW + 1)'(NUM_CH);

  // Convert a keep count into k ones, left-justified.
  function automatic logic [DATA_W-1:0] mask_of(input logic [KW-1:0] k);
    return ~({DATA_W{1'b1}} >> k);
  endfunction

  // Half of the lowest kept bit. A full-width keep has no dropped bits to round.
  function automatic logic [DATA_W-1:0] round_of(input logic [KW-1:0] k);
    if (k < K_MAX) return DATA_W'(1) << (K_MAX - k - K_MIN);
    else           return '0;
  endfunction

  function automatic logic [KW-1:0] def_keep(input int c);
    return KW'(DEF_KEEP[4*c +: 4]);
  endfunction

  logic [NUM_CH-1:0] ch_err;
  logic [NUM_CH-1:0] ch_set;
  logic              commit;
  logic              bad_ch;
  logic              pending_q, pending_d;
  logic              update_done_q;
  logic              cmd_err_q;

  // A commit copies the shadow as it was before any same-edge command.
  assign commit = frame_start & pending_q;
  assign bad_ch = cmd_valid & ({1'b0, cmd_ch} >= CH_LIM);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [KW-1:0]     shadow_q, shadow_d;
      logic [KW-1:0]     active_q;
      logic [DATA_W-1:0] mask_q;
      logic              err_c, set_c;
      logic              sel;

      assign sel = cmd_valid & (cmd_ch == CW'(gi));

      always_comb begin
        shadow_d = shadow_q;
        err_c    = 1'b0;
        set_c    = 1'b0;
        if (sel) begin
          case (cmd_op)
            OP_LOAD: begin
              set_c = 1'b1;
              if (cmd_val == '0) begin
                shadow_d = K_MIN;
                err_c    = 1'b1;
              end else if (cmd_val > K_MAX) begin
                shadow_d = K_MAX;
                err_c    = 1'b1;
              end else begin
                shadow_d = cmd_val;
              end
            end
            OP_INC: begin
              // A saturated step is rejected and leaves pending alone.
              if (shadow_q >= K_MAX) err_c = 1'b1;
              else begin
                shadow_d = shadow_q + K_MIN;
                set_c    = 1'b1;
              end
            end
            OP_DEC: begin
              if (shadow_q <= K_MIN) err_c = 1'b1;
              else begin
                shadow_d = shadow_q - K_MIN;
                set_c    = 1'b1;
              end
            end
            default: begin
              shadow_d = def_keep(gi);
              set_c    = 1'b1;
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          shadow_q <= def_keep(gi);
          active_q <= def_keep(gi);
          mask_q   <= mask_of(def_keep(gi));
        end else begin
          shadow_q <= shadow_d;
          if (commit) begin
            active_q <= shadow_q;
            mask_q   <= mask_of(shadow_q);
          end
        end
      end

`ifdef QTHRESH_ROUND_EN
      logic [DATA_W-1:0] round_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)      round_q <= round_of(def_keep(gi));
        else if (commit) round_q <= round_of(shadow_q);
      end
      assign round_out[gi*DATA_W +: DATA_W] = round_q;
`endif

      assign ch_err[gi]                    = err_c;
      assign ch_set[gi]                    = set_c;
      assign keep_out[gi*KW +: KW]         = active_q;
      assign mask_out[gi*DATA_W +: DATA_W] = mask_q;
    end
  endgenerate

  // A same-edge command re-arms pending even though the commit clears it.
  assign pending_d = (pending_q & ~commit) | (|ch_set);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q     <= 1'b0;
      update_done_q <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      update_done_q <= commit;
      cmd_err_q     <= (|ch_err) | bad_ch;
    end
  end

  assign pending     = pending_q;
  assign update_done = update_done_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_quant_threshold_bank.sv
module tb_quant_threshold_bank;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [1:0]  cmd_ch = 2'b00;
  logic [3:0]  cmd_val = 4'd0;
  logic        frame_start = 1'b0;
  logic [23:0] mask_out;
  logic [11:0] keep_out;
  logic        pending;
  logic        update_done;
  logic        cmd_err;
`ifdef QTHRESH_ROUND_EN
  logic [23:0] round_out;
`endif

  int n_vec = 0;
  int n_err = 0;

  quant_threshold_bank dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_ch      (cmd_ch),
    .cmd_val     (cmd_val),
    .frame_start (frame_start),
    .mask_out    (mask_out),
    .keep_out    (keep_out),
    .pending     (pending),
`ifdef QTHRESH_ROUND_EN
    .round_out   (round_out),
`endif
    .update_done (update_done),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one command for one cycle, then check cmd_err and pending.
  task automatic cmd(input logic [1:0] op, input logic [1:0] ch, input logic [3:0] val,
                     input logic exp_err, input logic exp_pend, input string tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = ch;
    cmd_val   = val;
    tick();
    cmd_valid = 1'b0;
    $display("cmd %s op=%0d ch=%0d val=%0d err=%0b pend=%0b", tag, op, ch, val, cmd_err, pending);
    check({tag, "_err"}, {31'd0, cmd_err}, {31'd0, exp_err});
    check({tag, "_pend"}, {31'd0, pending}, {31'd0, exp_pend});
  endtask

  // Pulse frame_start for one cycle, then check update_done and the active set.
  task automatic frame(input logic exp_done, input logic [23:0] exp_mask,
                       input logic [11:0] exp_keep, input string tag);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    $display("frame %s done=%0b mask=%h keep=%h pend=%0b", tag, update_done, mask_out, keep_out, pending);
    check({tag, "_done"}, {31'd0, update_done}, {31'd0, exp_done});
    check({tag, "_mask"}, {8'd0, mask_out}, {8'd0, exp_mask});
    check({tag, "_keep"}, {20'd0, keep_out}, {20'd0, exp_keep});
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mask", {8'd0, mask_out}, 32'h00C0C0E0);
    check("rst_keep", {20'd0, keep_out}, 32'h223);
    check("rst_pend", {31'd0, pending}, 32'd0);
    check("rst_done", {31'd0, update_done}, 32'd0);
    check("rst_err",  {31'd0, cmd_err}, 32'd0);
    reset = 1'b1;
    tick();
    $display("reset released mask=%h keep=%h", mask_out, keep_out);

    // LOAD ch0=5, with a commit three cycles later
    cmd(2'b00, 2'd0, 4'd5, 1'b0, 1'b1, "load0_5");
    check("load0_hold_mask", {8'd0, mask_out}, 32'h00C0C0E0);
    tick();
    check("load0_hold_pend", {31'd0, pending}, 32'd1);
    check("load0_hold_mask2", {8'd0, mask_out}, 32'h00C0C0E0);
    frame(1'b1, 24'hC0C0F8, 12'h225, "commit1");
    check("commit1_pend", {31'd0, pending}, 32'd0);
    tick();
    check("commit1_done_pulse", {31'd0, update_done}, 32'd0);

    // INC ch1 eight times from 2: saturates at 8 after six commands
    for (int i = 0; i < 8; i++)
      cmd(2'b01, 2'd1, 4'd0, (i >= 6), 1'b1, $sformatf("inc1_%0d", i));
    frame(1'b1, 24'hC0FFF8, 12'h285, "commit_inc");

    // DEC ch2 twice from 2, then LOAD 0 clamps to 1
    cmd(2'b10, 2'd2, 4'd0, 1'b0, 1'b1, "dec2_a");
    cmd(2'b10, 2'd2, 4'd0, 1'b1, 1'b1, "dec2_b");
    frame(1'b1, 24'h80FFF8, 12'h185, "commit_dec");
    cmd(2'b00, 2'd2, 4'd0, 1'b1, 1'b1, "load2_0");
    frame(1'b1, 24'h80FFF8, 12'h185, "commit_load0");

    // An invalid channel is rejected, and a frame with nothing pending does nothing
    cmd(2'b00, 2'd3, 4'd4, 1'b1, 1'b0, "badch");
    frame(1'b0, 24'h80FFF8, 12'h185, "idle_frame");

    // Same-cycle command and frame_start commits the earlier shadow
    cmd(2'b00, 2'd0, 4'd4, 1'b0, 1'b1, "load0_4");
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_ch = 2'd0; cmd_val = 4'd7;
    frame(1'b1, 24'h80FFF0, 12'h184, "commit_same");
    cmd_valid = 1'b0;
    check("same_pend", {31'd0, pending}, 32'd1);
`ifdef QTHRESH_ROUND_EN
    check("round_k4", {8'd0, round_out}, 32'h00400008);
`endif
    frame(1'b1, 24'h80FFFE, 12'h187, "commit_next");

    // RESTORE and LOAD clamp above DATA_W
    cmd(2'b11, 2'd1, 4'd0, 1'b0, 1'b1, "restore1");
    cmd(2'b00, 2'd2, 4'd15, 1'b1, 1'b1, "load2_15");
    frame(1'b1, 24'hFFC0FE, 12'h827, "commit_rst_clamp");

    // Reset mid-edit discards the shadow and restores the defaults at once
    cmd(2'b00, 2'd0, 4'd2, 1'b0, 1'b1, "load0_2");
    reset = 1'b0;
    #1;
    $display("async reset mask=%h keep=%h pend=%0b", mask_out, keep_out, pending);
    check("arst_mask", {8'd0, mask_out}, 32'h00C0C0E0);
    check("arst_keep", {20'd0, keep_out}, 32'h223);
    check("arst_pend", {31'd0, pending}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    frame(1'b0, 24'hC0C0E0, 12'h223, "post_reset_frame");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
